// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM encoding, address/instruction widths and reset PC.
package cpu_defs;

  localparam int ADDR_W_DEF   = 8;
  localparam int RESET_PC_DEF = 0;
  localparam int INSTR_W      = 16;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_RD_HI = 2'd1,
    IF_RD_LO = 2'd2
  } if_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load has priority over the +2 step; arithmetic wraps modulo 2**W.
module pc_counter #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_target,
  input  logic         i_inc,
  output logic [W-1:0] o_pc
);

  logic [W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VAL;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + W'(2);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Two-byte instruction fetch from an 8-bit synchronous ROM; owns the PC and presents the
// assembled 16-bit word to the decoder with a one-cycle instr_valid pulse.
module instruction_fetch
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_target,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [7:0]         rom_data,
  output logic [INSTR_W-1:0] Fetch,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output if_state_t          o_dbg_state
);

  // Handshake: fetch_req is a level request accepted only in IF_IDLE (ignored while busy, never
  // queued); pc_load is a one-cycle strobe that wins over everything; instr_valid pulses one cycle.

  if_state_t           r_state;
  if_state_t           w_next_state;
  logic                w_complete;
  logic                w_capture_hi;
  logic [7:0]          r_hi_byte;
  logic [INSTR_W-1:0]  r_fetch;
  logic                r_valid;
  logic [ADDR_W-1:0]   w_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IF_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_complete   = 1'b0;
    w_capture_hi = 1'b0;
    case (r_state)
      IF_IDLE: begin
        if (fetch_req) w_next_state = IF_RD_HI;
      end
      IF_RD_HI: begin
        w_capture_hi = 1'b1;
        w_next_state = IF_RD_LO;
      end
      IF_RD_LO: begin
        w_complete   = 1'b1;
        w_next_state = IF_IDLE;
      end
      default: w_next_state = IF_IDLE;
    endcase
    // A redirect aborts whatever is in flight, including a same-cycle request in IDLE.
    if (pc_load) begin
      w_next_state = IF_IDLE;
      w_complete   = 1'b0;
      w_capture_hi = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_byte <= 8'h00;
      r_valid   <= 1'b0;
      r_fetch   <= '0;
    end else begin
      r_valid <= w_complete;
      if (pc_load) begin
        r_hi_byte <= 8'h00;
      end else if (w_capture_hi) begin
        r_hi_byte <= rom_data;
      end
      if (r_valid) begin
        r_fetch <= {r_hi_byte, rom_data};
      end
    end
  end

  pc_counter #(
    .W         (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (pc_load),
    .i_target (pc_target),
    .i_inc    (w_complete),
    .o_pc     (w_pc)
  );

  // The low byte addressed in RD_LO only leaves the ROM in the following (valid) cycle, so
  // that cycle forwards it directly; the register holds the word from then on.
  assign Fetch       = r_valid ? {r_hi_byte, rom_data} : r_fetch;
  assign instr_valid = r_valid;
  assign rom_addr    = (r_state == IF_RD_LO) ? (w_pc + ADDR_W'(1)) : w_pc;
  assign pc          = w_pc;
  assign busy        = (r_state != IF_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous ROM model, directed scenarios, randomized fetch/jump/abort mix.
module tb_instruction_fetch;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] Fetch;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        busy;
  if_state_t   dbg_state;

  logic [7:0]  rom [256];
  logic [15:0] exp_q [$];
  logic [7:0]  m_pc;
  logic [15:0] m_fetch;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .Fetch       (Fetch),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  task automatic test_reset_initial();
    #3;
    n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h want 00", pc); end
    n_cmp++; if (Fetch !== 16'h0000) begin n_err++; $display("FAIL rst_fetch: got %h want 0000", Fetch); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'h00;
    m_fetch = 16'h0000;
  endtask

  task automatic test_basic();
    n_cmp++; if (rom_addr !== 8'h00) begin n_err++; $display("FAIL basic_addr_c0: got %h want 00", rom_addr); end
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    n_cmp++; if (rom_addr !== 8'h00) begin n_err++; $display("FAIL basic_addr_c1: got %h want 00", rom_addr); end
    n_cmp++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_c1: busy %b valid %b want 1 0", busy, instr_valid); end
    @(negedge clk);
    n_cmp++; if (rom_addr !== 8'h01) begin n_err++; $display("FAIL basic_addr_c2: got %h want 01", rom_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_c2: got %b want 0", instr_valid); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_c3: got %b want 1", instr_valid); end
    n_cmp++; if (Fetch !== 16'h1125) begin n_err++; $display("FAIL basic_fetch: got %h want 1125", Fetch); end
    n_cmp++; if (pc !== 8'h02 || busy !== 1'b0) begin n_err++; $display("FAIL basic_pc: pc %h busy %b want 02 0", pc, busy); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0 || Fetch !== 16'h1125) begin n_err++; $display("FAIL basic_hold: valid %b fetch %h want 0 1125", instr_valid, Fetch); end
    m_pc = 8'h02;
    m_fetch = 16'h1125;
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== IF_RD_LO) begin n_err++; $display("FAIL rmid_state: got %0d want %0d", dbg_state, IF_RD_LO); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL rmid_pc: got %h want 00", pc); end
    n_cmp++; if (Fetch !== 16'h0000) begin n_err++; $display("FAIL rmid_fetch: got %h want 0000", Fetch); end
    n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_flags: valid %b busy %b want 0 0", instr_valid, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_after: valid %b busy %b want 0 0", instr_valid, busy); end
    m_pc = 8'h00;
    m_fetch = 16'h0000;
  endtask

  task automatic test_back_to_back();
    fetch_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) begin
        n_cmp++; if (instr_valid !== 1'b1 || Fetch !== 16'h1125 || pc !== 8'h02) begin
          n_err++; $display("FAIL b2b_first: valid %b fetch %h pc %h want 1 1125 02", instr_valid, Fetch, pc);
        end
      end else if (c == 4 || c == 5) begin
        n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b1) begin
          n_err++; $display("FAIL b2b_gap_c%0d: valid %b busy %b want 0 1", c, instr_valid, busy);
        end
      end else if (c == 6) begin
        n_cmp++; if (instr_valid !== 1'b1 || Fetch !== 16'hC34A || pc !== 8'h04) begin
          n_err++; $display("FAIL b2b_second: valid %b fetch %h pc %h want 1 c34a 04", instr_valid, Fetch, pc);
        end
      end
      if (c == 4) fetch_req = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_end: valid %b busy %b want 0 0", instr_valid, busy); end
    m_pc = 8'h04;
    m_fetch = 16'hC34A;
  endtask

  task automatic test_abort();
    logic [15:0] want;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    pc_load = 1'b1;
    pc_target = 8'h40;
    @(negedge clk);
    pc_load = 1'b0;
    n_cmp++; if (dbg_state !== IF_IDLE || pc !== 8'h40 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_hi: state %0d pc %h valid %b want 0 40 0", dbg_state, pc, instr_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b0 || Fetch !== m_fetch) begin
        n_err++; $display("FAIL abort_quiet: valid %b fetch %h want 0 %h", instr_valid, Fetch, m_fetch);
      end
    end
    want = {rom[8'h40], rom[8'h41]};
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || Fetch !== want || pc !== 8'h42) begin
      n_err++; $display("FAIL abort_refetch: valid %b fetch %h pc %h want 1 %h 42", instr_valid, Fetch, pc, want);
    end
    m_fetch = want;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    pc_load = 1'b1;
    pc_target = 8'h10;
    @(negedge clk);
    pc_load = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || pc !== 8'h10 || Fetch !== m_fetch || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_lo: valid %b pc %h fetch %h busy %b want 0 10 %h 0", instr_valid, pc, Fetch, busy, m_fetch);
    end
    m_pc = 8'h10;
  endtask

  task automatic test_wrap();
    logic [15:0] want;
    pc_load = 1'b1;
    pc_target = 8'hFE;
    @(negedge clk);
    pc_load = 1'b0;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || Fetch !== 16'h9A01 || pc !== 8'h00) begin
      n_err++; $display("FAIL wrap_fe: valid %b fetch %h pc %h want 1 9a01 00", instr_valid, Fetch, pc);
    end
    want = {rom[8'hFF], rom[8'h00]};
    pc_load = 1'b1;
    pc_target = 8'hFF;
    @(negedge clk);
    pc_load = 1'b0;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (rom_addr !== 8'h00) begin n_err++; $display("FAIL wrap_addr_lo: got %h want 00", rom_addr); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || Fetch !== want || pc !== 8'h01) begin
      n_err++; $display("FAIL wrap_ff: valid %b fetch %h pc %h want 1 %h 01", instr_valid, Fetch, pc, want);
    end
    m_pc = 8'h01;
    m_fetch = want;
  endtask

  task automatic test_same_cycle();
    fetch_req = 1'b1;
    pc_load = 1'b1;
    pc_target = 8'h80;
    @(negedge clk);
    fetch_req = 1'b0;
    pc_load = 1'b0;
    n_cmp++; if (pc !== 8'h80 || busy !== 1'b0 || dbg_state !== IF_IDLE) begin
      n_err++; $display("FAIL same_cycle: pc %h busy %b state %0d want 80 0 0", pc, busy, dbg_state);
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_after: valid %b busy %b want 0 0", instr_valid, busy);
    end
    m_pc = 8'h80;
  endtask

  task automatic test_random();
    int          op;
    int          lat;
    int          ph;
    logic        seen;
    logic [7:0]  t;
    logic [7:0]  nxt;
    logic [15:0] want;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        nxt = m_pc + 8'd1;
        exp_q.push_back({rom[m_pc], rom[nxt]});
        fetch_req = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (lat < 8 && !seen) begin
          @(negedge clk);
          lat++;
          if (lat == 1) fetch_req = 1'($urandom_range(0, 1));
          if (lat >= 2) fetch_req = 1'b0;
          seen = instr_valid;
        end
        want = exp_q.pop_front();
        n_cmp++; if (!seen || lat != 3) begin
          n_err++; $display("FAIL rnd_latency: seen %b cycles %0d want 1 3", seen, lat);
        end
        n_cmp++; if (Fetch !== want || pc !== m_pc + 8'd2) begin
          n_err++; $display("FAIL rnd_fetch: fetch %h pc %h want %h %h", Fetch, pc, want, m_pc + 8'd2);
        end
        m_pc = m_pc + 8'd2;
        m_fetch = want;
      end else if (op == 3) begin
        t = 8'($urandom_range(0, 255));
        pc_load = 1'b1;
        pc_target = t;
        fetch_req = 1'($urandom_range(0, 1));
        @(negedge clk);
        pc_load = 1'b0;
        fetch_req = 1'b0;
        n_cmp++; if (pc !== t || busy !== 1'b0) begin
          n_err++; $display("FAIL rnd_jump: pc %h busy %b want %h 0", pc, busy, t);
        end
        m_pc = t;
      end else begin
        ph = $urandom_range(1, 2);
        t = 8'($urandom_range(0, 255));
        fetch_req = 1'b1;
        for (int k = 1; k <= ph; k++) begin
          @(negedge clk);
          fetch_req = 1'b0;
        end
        pc_load = 1'b1;
        pc_target = t;
        @(negedge clk);
        pc_load = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || pc !== t || Fetch !== m_fetch || busy !== 1'b0) begin
          n_err++; $display("FAIL rnd_abort_ph%0d: valid %b pc %h fetch %h busy %b want 0 %h %h 0",
                            ph, instr_valid, pc, Fetch, busy, t, m_fetch);
        end
        m_pc = t;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_req = 1'b0;
    pc_load = 1'b0;
    pc_target = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[8'h00] = 8'h11;
    rom[8'h01] = 8'h25;
    rom[8'h02] = 8'hC3;
    rom[8'h03] = 8'h4A;
    rom[8'hFE] = 8'h9A;
    rom[8'hFF] = 8'h01;
    test_reset_initial();
    test_basic();
    test_reset_mid();
    test_back_to_back();
    test_abort();
    test_wrap();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule
